digit_serial_addsub: RTL and testbench
======================================

Name: digit_serial_addsub

Overview:
Parametrised multi-cycle adder/subtractor. It is the sequential successor to the combinational half, full, 4-bit and 16-bit adder/subtractor set. Operands are latched on a start handshake and processed DIGIT bits per clock, LSB digit first, through one DIGIT-wide ripple adder slice. It reports the result with carry, signed-overflow and zero flags, and serves as the shared arithmetic unit for later datapath labs.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of DIGIT.
DIGIT, 4, bits processed per clock; 1 <= DIGIT <= WIDTH.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
start  input  1  request pulse; sampled on rising clk.
sub  input  1  0 = A+B, 1 = A-B; latched with operands.
a  input  WIDTH  operand A, two's complement.
b  input  WIDTH  operand B, two's complement.
busy  output  1  high while a computation is in progress.
done  output  1  single-cycle pulse marking result valid.
result  output  WIDTH  sum/difference.
carry_out  output  1  carry from MSB; for subtraction 1 = no borrow.
overflow  output  1  signed overflow of the operation.
zero  output  1  result == 0.

Behaviour:
- One clock; reset is asynchronous and active-high. Clock and reset ports are named clk and reset.
- Reset value of all outputs is 0. The FSM is forced to IDLE and internal digit counter, carry and shift registers are cleared. Reset asserted mid-operation aborts the operation; no done pulse follows.
- N = WIDTH/DIGIT. The digit counter is sized ceil(log2(N+1)).
- FSM states IDLE, RUN, DONE:
  - IDLE: start=1 latches a, b, sub, moves to RUN, count=0. Initial carry = sub.
  - RUN: busy=1. Each cycle adds digit[count] of A and the digit of B, with B inverted when sub=1, plus the running carry. The digit is shifted into the result register from the MSB side and the carry is registered. After the N-th digit the state moves to DONE.
  - DONE: busy=0, done=1 for exactly one cycle. result/carry_out/overflow/zero update on entry to DONE. Next state is IDLE, or RUN if start=1 in that cycle (back-to-back accepted).
- Latency: start sampled at edge k; busy high during cycles k..k+N-1; done high in the cycle following edge k+N. Throughput is one operation per N+1 cycles.
- start while busy=1 is ignored (no queueing). a/b/sub changes during RUN have no effect.
- result and flags hold their last values from done until the next DONE entry; they do not show partial digits.
- overflow = carry into MSB XOR carry out of MSB. It is computed in the final digit slice from the MSB-1 carry.
- zero is evaluated on the final (possibly saturated) result.
- DIGIT == WIDTH degenerates to N=1: one RUN cycle, done two cycles after start.

Optional Feature:
Macro DIGIT_SERIAL_SAT_EN.
- Defined: on overflow=1, result saturates to 0111...1 when the true result is positive (A's sign = 0) and to 1000...0 when negative. overflow is still reported as 1 and carry_out is unchanged.
- Not defined: result wraps modulo 2^WIDTH and no saturation logic is present.

Test Plan:
- Defaults, A=29, B=3, sub=0, start pulse -> busy high 4 cycles, done one cycle later, result=32, carry_out=0, overflow=0, zero=0.
- A=103, B=145, sub=1 -> result=0xFFD6 (-42), carry_out=0 (borrow), overflow=0.
- A=0x7FFF, B=1, sub=0 -> overflow=1; result=0x8000 without macro, 0x7FFF with DIGIT_SERIAL_SAT_EN.
- A=202, B=202, sub=1 -> result=0, zero=1, carry_out=1. Start re-pulsed during RUN with A=21, B=83 -> ignored, result still 0.
- Start A=21, B=83, then assert reset after 2 RUN cycles -> all outputs 0, no done pulse. A new start after release completes with result=104.
- WIDTH=8, DIGIT=8: A=0x80, B=0xFF, sub=0 -> done two cycles after start, result=0x7F, carry_out=1, overflow=1.

Source files
------------

// File: rtl/digit_serial_addsub.sv
// ---------------------------------------------------------------------------
// digit_serial_addsub
//
// Multi-cycle two's complement adder/subtractor. The operands are latched
// when start is accepted. They are then consumed DIGIT bits per clock, least
// significant digit first, through a single DIGIT-wide ripple slice. A
// WIDTH-bit operation therefore takes N = WIDTH/DIGIT RUN cycles. A one-cycle
// DONE state follows, in which the result and flags are presented.
//
// Optional build macro:
//   DIGIT_SERIAL_SAT_EN - when defined, a signed overflow saturates the
//                         result to the most positive value (A >= 0) or the
//                         most negative value (A < 0). When the macro is not
//                         defined, the result wraps modulo 2^WIDTH.
//
// Parameters:
//   WIDTH     operand/result width, must be a multiple of DIGIT
//   DIGIT     bits processed per clock, 1 <= DIGIT <= WIDTH
//
// Ports:
//   clk       system clock, rising edge
//   reset     asynchronous active-high reset
//   start     request; accepted in IDLE or DONE, ignored while busy
//   sub       0 = a + b, 1 = a - b (latched with the operands)
//   a, b      two's complement operands
//   busy      high while digits are being processed
//   done      one-cycle pulse; result and flags are valid from here on
//   result    sum / difference (holds until the next completion)
//   carry_out carry out of the MSB; for subtraction 1 means no borrow
//   overflow  signed overflow of the operation
//   zero      final result equals zero
// ---------------------------------------------------------------------------
module digit_serial_addsub #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_reg;
    state_t state_next;

    // Operand shift registers: the digit being processed always sits in the
    // low DIGIT bits. Later changes on a/b therefore cannot disturb a run.
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] a_shift;
    logic [WIDTH-1:0] b_shift;
    logic             sub_reg;
    logic             carry_reg;
    logic [CW-1:0]    count_reg;

    // Output registers. They are only written on the final digit, so partial
    // sums never appear on the ports.
    logic [WIDTH-1:0] result_reg;
    logic             carry_out_reg;
    logic             overflow_reg;
    logic             zero_reg;

`ifdef DIGIT_SERIAL_SAT_EN
    // The sign of A decides the saturation direction: on overflow the true
    // result has the same sign as A.
    logic             a_sign_reg;
`endif

    logic             accept;
    logic             last_digit;

    logic [DIGIT-1:0] a_dig;
    logic [DIGIT-1:0] b_dig;
    logic [DIGIT-1:0] sum_dig;
    logic [DIGIT:0]   chain;
    logic [WIDTH-1:0] acc_full;
    logic [WIDTH-1:0] final_result;
    logic             ovf_final;

    // A new request is taken in IDLE and also in DONE (back-to-back).
    assign accept     = start && ((state_reg == IDLE) || (state_reg == DONE));
    assign last_digit = (state_reg == RUN) && (count_reg == CW'(N - 1));

    // -----------------------------------------------------------------------
    // DIGIT-wide ripple slice. When subtracting, B is inverted, and the
    // initial carry (loaded with sub) supplies the +1.
    // -----------------------------------------------------------------------
    assign a_dig    = a_reg[DIGIT-1:0];
    assign b_dig    = b_reg[DIGIT-1:0] ^ {DIGIT{sub_reg}};
    assign chain[0] = carry_reg;

    generate
        for (genvar gi = 0; gi < DIGIT; gi++) begin : g_fa
            assign sum_dig[gi]   = a_dig[gi] ^ b_dig[gi] ^ chain[gi];
            assign chain[gi + 1] = (a_dig[gi] & b_dig[gi])
                                 | (a_dig[gi] & chain[gi])
                                 | (b_dig[gi] & chain[gi]);
        end
    endgenerate

    // On the final digit, chain[DIGIT-1] is the carry into the word MSB and
    // chain[DIGIT] is the carry out of it.
    assign ovf_final = chain[DIGIT] ^ chain[DIGIT-1];

    // -----------------------------------------------------------------------
    // Result assembly. New digits enter from the MSB side, so after N shifts
    // the first digit has reached bit 0. The multi-digit case keeps only the
    // WIDTH-DIGIT bits already produced. acc_full is the full word as it
    // would be after this cycle's shift.
    // -----------------------------------------------------------------------
    generate
        if (DIGIT == WIDTH) begin : g_single
            assign acc_full = sum_dig;
            assign a_shift  = '0;
            assign b_shift  = '0;
        end else begin : g_multi
            logic [WIDTH-DIGIT-1:0] acc_part_reg;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    acc_part_reg <= '0;
                end else if (state_reg == RUN) begin
                    acc_part_reg <= acc_full[WIDTH-1:DIGIT];
                end
            end

            assign acc_full = {sum_dig, acc_part_reg};
            assign a_shift  = {{DIGIT{1'b0}}, a_reg[WIDTH-1:DIGIT]};
            assign b_shift  = {{DIGIT{1'b0}}, b_reg[WIDTH-1:DIGIT]};
        end
    endgenerate

`ifdef DIGIT_SERIAL_SAT_EN
    logic [WIDTH-1:0] sat_pos;
    logic [WIDTH-1:0] sat_neg;

    // 0111..1 and 1000..0, built without a zero-width replication.
    assign sat_pos = {WIDTH{1'b1}} >> 1;
    assign sat_neg = ~sat_pos;

    always_comb begin
        final_result = acc_full;
        if (ovf_final) begin
            final_result = a_sign_reg ? sat_neg : sat_pos;
        end
    end
`else
    assign final_result = acc_full;
`endif

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start)      state_next = RUN;
            RUN:     if (last_digit) state_next = DONE;
            DONE:    state_next = start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM: outputs
    // -----------------------------------------------------------------------
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_reg)
            RUN:     busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // -----------------------------------------------------------------------
    // Datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_reg         <= '0;
            b_reg         <= '0;
            sub_reg       <= 1'b0;
            carry_reg     <= 1'b0;
            count_reg     <= '0;
            result_reg    <= '0;
            carry_out_reg <= 1'b0;
            overflow_reg  <= 1'b0;
            zero_reg      <= 1'b0;
`ifdef DIGIT_SERIAL_SAT_EN
            a_sign_reg    <= 1'b0;
`endif
        end else if (accept) begin
            a_reg     <= a;
            b_reg     <= b;
            sub_reg   <= sub;
            carry_reg <= sub;
            count_reg <= '0;
`ifdef DIGIT_SERIAL_SAT_EN
            a_sign_reg <= a[WIDTH-1];
`endif
        end else if (state_reg == RUN) begin
            a_reg     <= a_shift;
            b_reg     <= b_shift;
            carry_reg <= chain[DIGIT];
            count_reg <= count_reg + CW'(1);
            if (last_digit) begin
                result_reg    <= final_result;
                carry_out_reg <= chain[DIGIT];
                overflow_reg  <= ovf_final;
                zero_reg      <= (final_result == '0);
            end
        end
    end

    assign result    = result_reg;
    assign carry_out = carry_out_reg;
    assign overflow  = overflow_reg;
    assign zero      = zero_reg;

endmodule

// File: tb/tb_digit_serial_addsub.sv
// ---------------------------------------------------------------------------
// tb_digit_serial_addsub
//
// Self-checking bench for digit_serial_addsub.
//   dut   : WIDTH=16, DIGIT=4 (N=4)
//   dut8  : WIDTH=8,  DIGIT=8 (degenerate N=1)
// The expected values come from an arithmetic model that works on integers.
// The model is aware of DIGIT_SERIAL_SAT_EN.
// ---------------------------------------------------------------------------
module tb_digit_serial_addsub;

    localparam int W = 16;
    localparam int D = 4;
    localparam int N = W / D;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // 16-bit instance
    logic         start = 1'b0;
    logic         sub = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, carry_out, overflow, zero;
    logic [W-1:0] result;

    // 8-bit degenerate instance
    logic         start8 = 1'b0;
    logic         sub8 = 1'b0;
    logic [7:0]   a8 = '0;
    logic [7:0]   b8 = '0;
    logic         busy8, done8, carry_out8, overflow8, zero8;
    logic [7:0]   result8;

    digit_serial_addsub #(.WIDTH(W), .DIGIT(D)) dut (
        .clk(clk), .reset(reset), .start(start), .sub(sub), .a(a), .b(b),
        .busy(busy), .done(done), .result(result), .carry_out(carry_out),
        .overflow(overflow), .zero(zero)
    );

    digit_serial_addsub #(.WIDTH(8), .DIGIT(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .sub(sub8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .result(result8), .carry_out(carry_out8),
        .overflow(overflow8), .zero(zero8)
    );

    int tests = 0;
    int fails = 0;
    logic [W-1:0] prev_res = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on a w-bit word.
    function automatic void model(input int w, input longint ua, input longint ub, input bit s,
                                  output longint res, output bit c, output bit ov, output bit z);
        longint mask, half, bv, sum, sa, sb, t;
        mask = (longint'(1) << w) - 1;
        half = longint'(1) << (w - 1);
        bv   = s ? (~ub & mask) : ub;
        sum  = ua + bv + longint'(s);
        c    = ((sum >> w) & 1) != 0;
        res  = sum & mask;
        sa   = (ua >= half) ? ua - (mask + 1) : ua;
        sb   = (ub >= half) ? ub - (mask + 1) : ub;
        t    = s ? sa - sb : sa + sb;
        ov   = (t >= half) || (t < -half);
`ifdef DIGIT_SERIAL_SAT_EN
        if (ov) res = (sa >= 0) ? half - 1 : half;
`endif
        z    = (res == 0);
    endfunction

    // Launches one operation on the 16-bit DUT and returns at #1 after the
    // edge that enters DONE. If the caller then invokes op16 again straight
    // away, the new start is seen in DONE (back-to-back).
    task automatic op16(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input bit ts,
                        input bit repulse);
        longint er;
        bit ec, eo, ez;
        int lat;
        model(W, longint'(ta), longint'(tb_v), ts, er, ec, eo, ez);
        a = ta; b = tb_v; sub = ts; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
        check("busy_after_start", busy, 1);
        check("done_after_start", done, 0);
        lat = 0;
        while (!done && lat < 40) begin
            if (lat == 1) check("result_hold_in_run", result, prev_res);
            if (repulse && lat == 1) begin
                start = 1'b1; a = 16'd21; b = 16'd83; sub = 1'b0;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        check("latency", lat, N);
        check("done", done, 1);
        check("busy_in_done", busy, 0);
        check("result", result, er[W-1:0]);
        check("carry_out", carry_out, ec);
        check("overflow", overflow, eo);
        check("zero", zero, ez);
        prev_res = er[W-1:0];
        $display("[TB] op16 a=%h b=%h sub=%0d -> result=%h c=%0d v=%0d z=%0d lat=%0d",
                 ta, tb_v, ts, result, carry_out, overflow, zero, lat);
    endtask

    task automatic idle_tick();
        @(posedge clk); #1;
        check("done_single_pulse", done, 0);
        check("busy_idle", busy, 0);
    endtask

    task automatic op8(input logic [7:0] ta, input logic [7:0] tb_v, input bit ts);
        longint er;
        bit ec, eo, ez;
        int lat;
        model(8, longint'(ta), longint'(tb_v), ts, er, ec, eo, ez);
        a8 = ta; b8 = tb_v; sub8 = ts; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        check("busy8_after_start", busy8, 1);
        lat = 0;
        while (!done8 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency8", lat, 1);
        check("result8", result8, er[7:0]);
        check("carry8", carry_out8, ec);
        check("overflow8", overflow8, eo);
        check("zero8", zero8, ez);
        $display("[TB] op8 a=%h b=%h sub=%0d -> result=%h c=%0d v=%0d z=%0d lat=%0d",
                 ta, tb_v, ts, result8, carry_out8, overflow8, zero8, lat);
        @(posedge clk); #1;
        check("done8_single_pulse", done8, 0);
    endtask

    initial begin
        int seen;
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        check("rst_carry", carry_out, 0);
        check("rst_overflow", overflow, 0);
        check("rst_zero", zero, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Directed cases
        op16(16'd29, 16'd3, 1'b0, 1'b0);       idle_tick();
        op16(16'd103, 16'd145, 1'b1, 1'b0);    idle_tick();
        op16(16'h7FFF, 16'd1, 1'b0, 1'b0);     idle_tick();
        op16(16'h8000, 16'd1, 1'b1, 1'b0);     idle_tick();
        op16(16'd202, 16'd202, 1'b1, 1'b1);    idle_tick();
        check("repulse_ignored_result", result, 0);

        // Back-to-back chain
        op16(16'h1234, 16'h4321, 1'b0, 1'b0);
        op16(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        op16(16'h0000, 16'h0001, 1'b1, 1'b0);  idle_tick();

        // Randomized operations, mixing idle gaps and back-to-back starts
        for (int i = 0; i < 24; i++) begin
            op16(W'($urandom), W'($urandom), 1'($urandom), 1'b0);
            if ($urandom_range(0, 1) == 1) idle_tick();
        end
        idle_tick();

        // Leave non-zero outputs in place, then abort a run with reset
        op16(16'h7FFF, 16'd1, 1'b0, 1'b0);     idle_tick();
        a = 16'd21; b = 16'd83; sub = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_result", result, 0);
        check("abort_carry", carry_out, 0);
        check("abort_overflow", overflow, 0);
        check("abort_zero", zero, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        seen = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
        check("no_done_after_abort", seen, 0);
        prev_res = '0;
        op16(16'd21, 16'd83, 1'b0, 1'b0);      idle_tick();

        // Degenerate WIDTH == DIGIT instance
        op8(8'h80, 8'hFF, 1'b0);
        op8(8'h7F, 8'h01, 1'b0);
        op8(8'h05, 8'h05, 1'b1);
        for (int i = 0; i < 6; i++) begin
            op8(8'($urandom), 8'($urandom), 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Hard time limit so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
